// File: rtl/dec_fifo_out.sv
// Decimating first-word-fall-through output FIFO for the smoothing filter stream.
// It keeps 1 of every i_dec+1 valid samples, buffers them, and records overflow drops.
module dec_fifo_out #(
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3,
   parameter int unsigned CW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] i_data,
   input  logic          i_valid,
   input  logic [3:0]    i_dec,
   input  logic          i_clr,
   input  logic          i_ready,
   output logic [DW-1:0] o_data,
   output logic          o_valid,
   output logic [AW:0]   o_level,
   output logic          o_ovf,
   output logic [CW-1:0] o_drop
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [3:0]    ph_q,    ph_d;
   logic [AW-1:0] wptr_q,  wptr_d;
   logic [AW-1:0] rptr_q,  rptr_d;
   logic [AW:0]   level_q, level_d;
   logic          ovf_q,   ovf_d;
   logic [CW-1:0] drop_q,  drop_d;
   logic [DW-1:0] mem_q [DEPTH];

   logic keep, pop, push, drop;

   // Decimation, FIFO occupancy and overflow bookkeeping.
   always_comb begin
      ph_d    = ph_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      ovf_d   = ovf_q;
      drop_d  = drop_q;

      keep = i_valid && (ph_q == 4'd0);
      pop  = (level_q != '0) && i_ready;
      // When full, a same-cycle pop frees the slot for the incoming sample.
      push = keep && ((level_q != FULL_LVL) || pop);
      drop = keep && !push;

      if (i_valid) begin
         ph_d = (ph_q >= i_dec) ? 4'd0 : ph_q + 4'd1;
      end

      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);

      if (push && !pop)      level_d = level_q + (AW+1)'(1);
      else if (pop && !push) level_d = level_q - (AW+1)'(1);

      // A drop in the same cycle as a clear takes precedence over the clear.
      if (drop) begin
         ovf_d  = 1'b1;
         drop_d = i_clr ? CW'(1) : ((drop_q == '1) ? drop_q : drop_q + CW'(1));
      end else if (i_clr) begin
         ovf_d  = 1'b0;
         drop_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ph_q    <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         ph_q    <= ph_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   // Storage is deliberately left uninitialised by reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= i_data;
   end

   assign o_data  = mem_q[rptr_q];
   assign o_valid = (level_q != '0);
   assign o_level = level_q;
   assign o_ovf   = ovf_q;
   assign o_drop  = drop_q;

endmodule

// File: doc/dec_fifo_out.md
Name: dec_fifo_out

Overview:
- Downstream consumer of the 32-bit smoothing filter output.
- Decimates the filtered sample stream by a runtime factor and buffers the kept samples in a small first-word-fall-through FIFO.
- Hands samples to the next stage over a valid/ready handshake.
- Reports overflow as a sticky flag plus a saturating drop counter.

Parameters:
- DW, 32, sample width; matches the filter output.
- DEPTH, 8, FIFO entries; must be a power of 2 and ≥ 2.
- AW, 3, pointer width = log2(DEPTH).
- CW, 8, drop counter width.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_data  input  DW  filtered sample from upstream filter.
- i_valid  input  1  i_data valid this cycle; upstream never stalls.
- i_dec  input  4  decimation factor minus 1; keep 1 of every i_dec+1 valid samples.
- i_clr  input  1  synchronous clear of o_ovf and o_drop.
- i_ready  input  1  downstream accepts o_data this cycle.
- o_data  output  DW  FIFO head sample.
- o_valid  output  1  FIFO not empty.
- o_level  output  AW+1  entries currently stored, 0..DEPTH.
- o_ovf  output  1  sticky: a kept sample was dropped because the FIFO was full.
- o_drop  output  CW  count of dropped kept samples, saturates at all-ones.

Behaviour:
- Reset:
  - Active when rst=1 at a clk edge; synchronous only.
  - Clears the phase counter, read/write pointers, o_level, o_ovf and o_drop to 0. o_valid=0.
  - o_data reads the head storage slot and is don't-care while o_valid=0; storage is not cleared.
  - Reset mid-transfer discards all buffered samples. The first valid sample after reset is kept (phase 0).
- Decimation:
  - 4-bit phase counter ph advances only on i_valid=1.
  - If ph ≥ i_dec, ph ← 0; otherwise ph ← ph+1.
  - A sample is "kept" when i_valid=1 and ph==0.
  - i_dec=0 keeps every valid sample.
  - A change of i_dec takes effect immediately. If ph already exceeds the new i_dec, the next valid sample wraps ph to 0 without being kept.
- Push:
  - A kept sample writes to mem[wptr] and wptr increments, mod DEPTH.
  - The push is accepted when o_level < DEPTH, or when o_level == DEPTH and a pop occurs in the same cycle.
- Drop:
  - A kept sample that is not accepted is discarded.
  - o_ovf ← 1. o_drop ← o_drop+1, holding at 2^CW−1.
  - If i_clr=1 in the same cycle, the drop wins: o_ovf=1 and o_drop=1 the next cycle.
  - Otherwise i_clr=1 sets o_ovf and o_drop to 0.
- Pop / FWFT:
  - o_valid = (o_level != 0).
  - o_data = mem[rptr], combinational from storage.
  - Pop when o_valid && i_ready; rptr increments mod DEPTH.
  - i_ready while empty has no effect.
- Level:
  - o_level is registered.
  - Push only: +1. Pop only: −1. Push and pop in the same cycle: unchanged.
- Latency:
  - A sample kept at edge N is visible on o_data/o_valid after edge N (one cycle) when the FIFO was empty.
  - No combinational path from i_data to o_data.
- Pointers: wrap naturally at DEPTH. Full and empty are distinguished by o_level, not by pointer equality.
- Arithmetic: data is passed unmodified, with no sign or width change.

Test Plan:
1. Reset, then i_dec=0, i_ready=1, 5 valid samples 10..14 → o_data 10..14 on consecutive cycles, each one cycle after input; o_level ≤ 1; o_ovf=0.
2. i_dec=2, i_ready=1, valid samples 1..9 → output sequence 1,4,7 only. Insert i_valid=0 gaps → same sequence; ph does not advance during gaps.
3. i_dec=0, i_ready=0, 12 valid samples 100..111 → o_level saturates at 8, o_data=100, o_ovf=1, o_drop=4. Then i_ready=1 → outputs 100..107, o_valid drops after the 8th.
4. FIFO full (o_level=8), i_ready=1 and a kept sample in the same cycle → sample accepted, o_level stays 8, o_drop unchanged.
5. o_drop at 255 plus one more drop → o_drop stays 255. Then i_clr=1 → o_ovf=0, o_drop=0. Repeat with i_clr coinciding with a drop → o_ovf=1, o_drop=1.
6. With 5 entries buffered and ph=1, assert rst=1 for one cycle → o_valid=0 and o_level=0 after the edge; the next valid sample after deassert is output first.
